// File: rtl/mm3_seq.sv
// Operand sequencer and result collector for a pipelined 3-element dot-product unit.
// Optional start-to-done cycle counter enabled by defining MM3_SEQ_CYCLE_COUNT_EN.
module mm3_seq #(
  parameter int BITS = 32,
  parameter int LAT  = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [3:0]      wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            start,
  output logic [BITS-1:0] a1,
  output logic [BITS-1:0] a2,
  output logic [BITS-1:0] a3,
  output logic [BITS-1:0] b1,
  output logic [BITS-1:0] b2,
  output logic [BITS-1:0] b3,
  output logic            issue_valid,
  input  logic [BITS-1:0] dp_out,
  input  logic [3:0]      rd_addr,
  output logic [BITS-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic [15:0]     cyc_count,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_k;
  logic [BITS-1:0] r_a [9];
  logic [BITS-1:0] r_b [9];
  logic [BITS-1:0] r_c [9];
  logic            r_pv [LAT];
  logic [3:0]      r_pk [LAT];
  logic            r_cap_last;
  logic [BITS-1:0] r_rd_data;
  logic            w_start_ok;
  logic            w_issue;
  logic [3:0]      w_row;
  logic [3:0]      w_row_base;
  logic [3:0]      w_col;

  // The DONE cycle also accepts start so back-to-back runs lose only one cycle.
  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue    = (r_state == S_ISSUE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (r_k == 4'd8) w_next = S_DRAIN;
      S_DRAIN: if (r_cap_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_ISSUE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                        r_k <= 4'd0;
    else if (w_start_ok)              r_k <= 4'd0;
    else if (w_issue && r_k != 4'd8)  r_k <= r_k + 4'd1;
  end

  always_comb begin
    w_row      = r_k / 4'd3;
    w_row_base = w_row * 4'd3;
    w_col      = r_k - w_row_base;
  end

  // Row i of A against column j of B; operands forced to zero outside ISSUE.
  assign a1 = w_issue ? r_a[w_row_base]        : '0;
  assign a2 = w_issue ? r_a[w_row_base + 4'd1] : '0;
  assign a3 = w_issue ? r_a[w_row_base + 4'd2] : '0;
  assign b1 = w_issue ? r_b[w_col]             : '0;
  assign b2 = w_issue ? r_b[w_col + 4'd3]      : '0;
  assign b3 = w_issue ? r_b[w_col + 4'd6]      : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (wr_en && r_state == S_IDLE && wr_addr <= 4'd8) begin
      if (wr_sel) r_b[wr_addr] <= wr_data;
      else        r_a[wr_addr] <= wr_data;
    end
  end

  // Valid pipeline: head entry marks the edge on which dp_out belongs to C[k].
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pk[i] <= 4'd0;
      end
      r_cap_last <= 1'b0;
      for (int i = 0; i < 9; i++) r_c[i] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pk[0] <= r_k;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pk[i] <= r_pk[i-1];
      end
      r_cap_last <= r_pv[LAT-1] && (r_pk[LAT-1] == 4'd8);
      if (r_pv[LAT-1] && r_pk[LAT-1] <= 4'd8) r_c[r_pk[LAT-1]] <= dp_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                r_rd_data <= '0;
    else if (rd_addr <= 4'd8) r_rd_data <= r_c[rd_addr];
    else                      r_rd_data <= '0;
  end

`ifdef MM3_SEQ_CYCLE_COUNT_EN
  logic [15:0] r_cyc;

  // Counting stops in DONE so the value holds at start-to-done latency.
  always_ff @(posedge clock) begin
    if (reset)                                      r_cyc <= 16'd0;
    else if (w_start_ok)                            r_cyc <= 16'd0;
    else if (r_state == S_ISSUE || r_state == S_DRAIN) r_cyc <= r_cyc + 16'd1;
  end

  assign cyc_count = r_cyc;
`else
  assign cyc_count = 16'd0;
`endif

  assign issue_valid = w_issue;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign rd_data     = r_rd_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mm3_seq.sv
// Directed bench for mm3_seq: the dot-product unit is modelled as an LAT-cycle delay of a1.
module tb_mm3_seq;
  localparam int BITS = 32;
  localparam int LAT  = 18;
  localparam logic [15:0] EXP_CYC =
`ifdef MM3_SEQ_CYCLE_COUNT_EN
    16'd28;
`else
    16'd0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            wr_en;
  logic            wr_sel;
  logic [3:0]      wr_addr;
  logic [BITS-1:0] wr_data;
  logic            start;
  logic [BITS-1:0] a1, a2, a3, b1, b2, b3;
  logic            issue_valid;
  logic [BITS-1:0] dp_out;
  logic [3:0]      rd_addr;
  logic [BITS-1:0] rd_data;
  logic            busy;
  logic            done;
  logic [15:0]     cyc_count;
  logic [1:0]      dbg_state;

  mm3_seq #(.BITS(BITS), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .issue_valid(issue_valid), .dp_out(dp_out), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .cyc_count(cyc_count),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // dot-product unit model: result is a1 delayed by LAT cycles
  logic [BITS-1:0] dl [LAT];
  always @(posedge clock) begin
    dl[0] <= a1;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign dp_out = dl[LAT-1];

  typedef struct {
    logic [3:0]      addr;
    logic [BITS-1:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [BITS-1:0] a1, a2, a3, b1, b2, b3;
  } op_vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  rd_vec_t rd_tab [11];
  op_vec_t op_tab [9];
  op_vec_t got_ops [9];

  int          iv_first, iv_last, iv_cnt, done_at, done_cnt;
  logic        busy_after;
  logic [15:0] cyc_at_done;
  logic [BITS-1:0] idle_ops;
  logic [BITS-1:0] rd_val;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_el(input logic sel, input logic [3:0] addr, input logic [BITS-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_c(input logic [3:0] addr, output logic [BITS-1:0] data);
    rd_addr = addr;
    tick();
    data = rd_data;
  endtask

  // Start a run and observe 41 cycles after the start edge; at cycle 'guard' a
  // start plus a write of A[0] is driven while busy.
  task automatic run_watch(input int guard);
    iv_first = -1; iv_last = -1; iv_cnt = 0; done_at = -1; done_cnt = 0;
    busy_after = 1'b1; cyc_at_done = 16'hFFFF; idle_ops = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (issue_valid) begin
        if (iv_first < 0) iv_first = n;
        iv_last = n;
        if (iv_cnt < 9) got_ops[iv_cnt] = '{a1, a2, a3, b1, b2, b3};
        iv_cnt++;
      end
      if (n == 10) idle_ops = a1 | a2 | a3 | b1 | b2 | b3;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          cyc_at_done = cyc_count;
        end
      end
      if (done_at >= 0 && n == done_at + 1) busy_after = busy;
      if (n == guard) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'hDEADBEEF;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    int d;
    int dcnt;

    // C contents after the latency run (A[e] = e+1): C[k] = A[3*(k/3)]
    rd_tab[0]  = '{4'd0,  32'd1};
    rd_tab[1]  = '{4'd1,  32'd1};
    rd_tab[2]  = '{4'd2,  32'd1};
    rd_tab[3]  = '{4'd3,  32'd4};
    rd_tab[4]  = '{4'd4,  32'd4};
    rd_tab[5]  = '{4'd5,  32'd4};
    rd_tab[6]  = '{4'd6,  32'd7};
    rd_tab[7]  = '{4'd7,  32'd7};
    rd_tab[8]  = '{4'd8,  32'd7};
    rd_tab[9]  = '{4'd9,  32'd0};
    rd_tab[10] = '{4'd15, 32'd0};

    // Operand sets for A = identity, B[e] = 0x40000000 + e
    op_tab[0] = '{32'h3F800000, 32'h0, 32'h0, 32'h40000000, 32'h40000003, 32'h40000006};
    op_tab[1] = '{32'h3F800000, 32'h0, 32'h0, 32'h40000001, 32'h40000004, 32'h40000007};
    op_tab[2] = '{32'h3F800000, 32'h0, 32'h0, 32'h40000002, 32'h40000005, 32'h40000008};
    op_tab[3] = '{32'h0, 32'h3F800000, 32'h0, 32'h40000000, 32'h40000003, 32'h40000006};
    op_tab[4] = '{32'h0, 32'h3F800000, 32'h0, 32'h40000001, 32'h40000004, 32'h40000007};
    op_tab[5] = '{32'h0, 32'h3F800000, 32'h0, 32'h40000002, 32'h40000005, 32'h40000008};
    op_tab[6] = '{32'h0, 32'h0, 32'h3F800000, 32'h40000000, 32'h40000003, 32'h40000006};
    op_tab[7] = '{32'h0, 32'h0, 32'h3F800000, 32'h40000001, 32'h40000004, 32'h40000007};
    op_tab[8] = '{32'h0, 32'h0, 32'h3F800000, 32'h40000002, 32'h40000005, 32'h40000008};

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = '0;
    start = 1'b0; rd_addr = 4'd0;
    repeat (LAT + 2) tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_a1", a1, 32'd0);
    check("rst_b3", b3, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_cyc_count", 32'(cyc_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // latency run
    for (int e = 0; e < 9; e++) write_el(1'b0, 4'(e), 32'(e + 1));
    run_watch(-1);
    check("lat_iv_first", 32'(iv_first), 32'd0);
    check("lat_iv_last", 32'(iv_last), 32'd8);
    check("lat_iv_cnt", 32'(iv_cnt), 32'd9);
    check("lat_done_at", 32'(done_at), 32'd28);
    check("lat_done_cnt", 32'(done_cnt), 32'd1);
    check("lat_busy_after_done", 32'(busy_after), 32'd0);
    check("lat_cyc_at_done", 32'(cyc_at_done), 32'(EXP_CYC));
    check("lat_cyc_held", 32'(cyc_count), 32'(EXP_CYC));
    for (int v = 0; v < 11; v++) begin
      read_c(rd_tab[v].addr, rd_val);
      check($sformatf("lat_c[%0d]", rd_tab[v].addr), rd_val, rd_tab[v].exp);
    end

    // operand order run
    for (int e = 0; e < 9; e++) begin
      write_el(1'b0, 4'(e), (e == 0 || e == 4 || e == 8) ? 32'h3F800000 : 32'h0);
      write_el(1'b1, 4'(e), 32'h40000000 + 32'(e));
    end
    run_watch(-1);
    check("ord_iv_cnt", 32'(iv_cnt), 32'd9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("ord_k%0d_a1", k), got_ops[k].a1, op_tab[k].a1);
      check($sformatf("ord_k%0d_a2", k), got_ops[k].a2, op_tab[k].a2);
      check($sformatf("ord_k%0d_a3", k), got_ops[k].a3, op_tab[k].a3);
      check($sformatf("ord_k%0d_b1", k), got_ops[k].b1, op_tab[k].b1);
      check($sformatf("ord_k%0d_b2", k), got_ops[k].b2, op_tab[k].b2);
      check($sformatf("ord_k%0d_b3", k), got_ops[k].b3, op_tab[k].b3);
    end
    check("ord_idle_ops_zero", idle_ops, 32'd0);
    read_c(4'd0, rd_val);
    check("ord_c0", rd_val, 32'h3F800000);
    read_c(4'd4, rd_val);
    check("ord_c4", rd_val, 32'h0);

    // busy guards: start and A[0] write at cycle 5 are ignored
    run_watch(5);
    check("guard_done_at", 32'(done_at), 32'd28);
    check("guard_done_cnt", 32'(done_cnt), 32'd1);
    check("guard_iv_cnt", 32'(iv_cnt), 32'd9);
    run_watch(-1);
    read_c(4'd0, rd_val);
    check("guard_a0_kept", rd_val, 32'h3F800000);

    // back-to-back: start held during the done cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    d = 0;
    while (!done && d < 40) begin
      tick();
      d++;
    end
    check("b2b_first_done", 32'(d), 32'd28);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accept", 32'(issue_valid), 32'd1);
    d = 1;
    while (!done && d < 60) begin
      tick();
      d++;
    end
    check("b2b_gap", 32'(d), 32'd29);
    check("b2b_cyc_count", 32'(cyc_count), 32'(EXP_CYC));
    repeat (3) tick();

    // reset mid-run: late results must be discarded
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'd0);
    check("mrst_issue_valid", 32'(issue_valid), 32'd0);
    reset = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (done) dcnt++;
      tick();
    end
    check("mrst_no_done", 32'(dcnt), 32'd0);
    check("mrst_busy_late", 32'(busy), 32'd0);
    check("mrst_cyc_count", 32'(cyc_count), 32'd0);
    for (int k = 0; k < 9; k++) begin
      read_c(4'(k), rd_val);
      check($sformatf("mrst_c[%0d]", k), rd_val, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
